// File: rtl/ins_fetcher_pkg.sv
// Shared types for the instruction fetch stage: FSM encoding and fetch-queue payload.
package ins_fetcher_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            taken;
    logic [XLEN-1:0] pred_pc;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // The icache is word addressed; low address bits are never meaningful on the request.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ins_fetcher_if.sv
// Fetch-stage bus bundle: icache request/response, predictor glue, issue port and ROB redirect.
interface ins_fetcher_if;
  import ins_fetcher_pkg::*;

  logic            ic_req_valid;
  logic [XLEN-1:0] ic_req_pc;
  logic            ic_resp_valid;
  logic [XLEN-1:0] ic_resp_inst;

  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            predict_res;
  logic [XLEN-1:0] predict_pc;

  logic            iss_valid;
  logic [XLEN-1:0] iss_pc;
  logic [XLEN-1:0] iss_inst;
  logic            iss_pred_taken;
  logic [XLEN-1:0] iss_pred_pc;
  logic            iss_ready;

  logic            rob_flush;
  logic [XLEN-1:0] rob_new_pc;

  modport master (
    output ic_req_valid, ic_req_pc,
    input  ic_resp_valid, ic_resp_inst,
    output if_pc, if_inst,
    input  predict_res, predict_pc,
    output iss_valid, iss_pc, iss_inst, iss_pred_taken, iss_pred_pc,
    input  iss_ready,
    input  rob_flush, rob_new_pc
  );

  modport slave (
    input  ic_req_valid, ic_req_pc,
    output ic_resp_valid, ic_resp_inst,
    input  if_pc, if_inst,
    output predict_res, predict_pc,
    input  iss_valid, iss_pc, iss_inst, iss_pred_taken, iss_pred_pc,
    output iss_ready,
    output rob_flush, rob_new_pc
  );

endinterface

// File: rtl/ins_fetcher_fetch_fifo.sv
// Fetch queue: circular buffer of fetch entries with push, pop, clear and a live count.
module fetch_fifo
  import ins_fetcher_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [CNT_W-1:0] count,
  output logic         empty
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q < CNT_W'(DEPTH)) || do_pop);
  end

  // Clear wins over push/pop; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (en) begin
      if (clear) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (do_push) begin
          mem_d[wr_ptr_q] = push_data;
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetch stage: PC, icache request FSM, predictor glue and the fetch queue.
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  ins_fetcher_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic             flush;
  logic             resp;
  logic             can_fetch;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_wdata;
  fetch_entry_t     fifo_head;

  assign flush     = bus.rob_flush;
  assign resp      = bus.ic_resp_valid;
  // Conservative: a same-cycle pop does not free a slot for a new request.
  assign can_fetch = (fifo_count < CNT_W'(FIFO_DEPTH));

  // State register; rdy=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IF_IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= RESET_PC;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_IDLE: if (!flush && can_fetch) state_d = IF_WAIT;
      IF_WAIT: begin
        if (flush)     state_d = resp ? IF_IDLE : IF_DROP;
        else if (resp) state_d = IF_IDLE;
      end
      IF_DROP: if (resp) state_d = IF_IDLE;
      default: state_d = IF_IDLE;
    endcase
  end

  // Datapath and queue controls; a flush overrides push, pop and new requests.
  always_comb begin
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_pc_d    = req_pc_q;
    fifo_push   = 1'b0;
    fifo_pop    = !fifo_empty && bus.iss_ready && !flush;
    fifo_wdata  = '{pc: pc_q, inst: bus.ic_resp_inst, taken: bus.predict_res,
                    pred_pc: bus.predict_pc};
    if (flush) pc_d = bus.rob_new_pc;
    unique case (state_q)
      IF_IDLE: begin
        if (!flush && can_fetch) begin
          req_valid_d = 1'b1;
          req_pc_d    = word_align(pc_q);
        end
      end
      IF_WAIT: begin
        if (resp) begin
          req_valid_d = 1'b0;
          if (!flush) begin
            fifo_push = 1'b1;
            pc_d      = bus.predict_pc;
          end
        end
      end
      IF_DROP: if (resp) req_valid_d = 1'b0;
      default: req_valid_d = 1'b0;
    endcase
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .clear     (flush),
    .push_data (fifo_wdata),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.ic_req_valid   = req_valid_q;
  assign bus.ic_req_pc      = req_pc_q;
  assign bus.if_pc          = pc_q;
  // Zero is a non-branch, so the predictor answers pc+4 / not-taken when idle.
  assign bus.if_inst        = (state_q == IF_WAIT && resp) ? bus.ic_resp_inst : '0;
  assign bus.iss_valid      = !fifo_empty;
  assign bus.iss_pc         = fifo_head.pc;
  assign bus.iss_inst       = fifo_head.inst;
  assign bus.iss_pred_taken = fifo_head.taken;
  assign bus.iss_pred_pc    = fifo_head.pred_pc;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher: vector table for the fetch stream plus hand sequences.
module tb_ins_fetcher;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] BEQ = 32'hFE000EE3;

  typedef struct {
    logic [31:0] exp_req_pc;
    int          lat;
    logic [31:0] inst;
    logic        exp_taken;
    logic [31:0] exp_pred_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [6];

  ins_fetcher_if bus ();

  ins_fetcher #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in predictor: only the test branch is predicted taken, target pc-4.
  assign bus.predict_res = (bus.if_inst == BEQ);
  assign bus.predict_pc  = bus.predict_res ? bus.if_pc - 32'd4 : bus.if_pc + 32'd4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20; k++) begin
      if (bus.ic_req_valid) return;
      step();
    end
    chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic serve(input int lat, input logic [31:0] inst);
    wait_req();
    repeat (lat - 1) step();
    bus.ic_resp_valid = 1'b1;
    bus.ic_resp_inst  = inst;
    step();
    bus.ic_resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_req;
    vecs[0] = '{32'h00, 3, NOP, 1'b0, 32'h04};
    vecs[1] = '{32'h04, 3, NOP, 1'b0, 32'h08};
    vecs[2] = '{32'h08, 3, NOP, 1'b0, 32'h0C};
    vecs[3] = '{32'h0C, 2, NOP, 1'b0, 32'h10};
    vecs[4] = '{32'h10, 1, BEQ, 1'b1, 32'h0C};
    vecs[5] = '{32'h0C, 2, NOP, 1'b0, 32'h10};

    rst = 1'b1;
    rdy = 1'b1;
    bus.ic_resp_valid = 1'b0;
    bus.ic_resp_inst  = '0;
    bus.iss_ready     = 1'b0;
    bus.rob_flush     = 1'b0;
    bus.rob_new_pc    = '0;
    step();
    step();
    chk("rst req_valid", 32'(bus.ic_req_valid), 32'd0);
    chk("rst req_pc", bus.ic_req_pc, 32'h0);
    chk("rst iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("rst if_pc", bus.if_pc, 32'h0);
    rst = 1'b0;

    // Fetch stream: each word is pushed, checked at the head, then popped.
    for (int i = 0; i < 6; i++) begin
      wait_req();
      chk($sformatf("v%0d req_pc", i), bus.ic_req_pc, vecs[i].exp_req_pc);
      chk($sformatf("v%0d if_inst idle", i), bus.if_inst, 32'h0);
      repeat (vecs[i].lat - 1) step();
      bus.ic_resp_valid = 1'b1;
      bus.ic_resp_inst  = vecs[i].inst;
      #1;
      chk($sformatf("v%0d if_inst", i), bus.if_inst, vecs[i].inst);
      chk($sformatf("v%0d if_pc", i), bus.if_pc, vecs[i].exp_req_pc);
      step();
      bus.ic_resp_valid = 1'b0;
      chk($sformatf("v%0d iss_valid", i), 32'(bus.iss_valid), 32'd1);
      chk($sformatf("v%0d iss_pc", i), bus.iss_pc, vecs[i].exp_req_pc);
      chk($sformatf("v%0d iss_inst", i), bus.iss_inst, vecs[i].inst);
      chk($sformatf("v%0d iss_taken", i), 32'(bus.iss_pred_taken), 32'(vecs[i].exp_taken));
      chk($sformatf("v%0d iss_pred_pc", i), bus.iss_pred_pc, vecs[i].exp_pred_pc);
      bus.iss_ready = 1'b1;
      step();
      bus.iss_ready = 1'b0;
      chk($sformatf("v%0d popped", i), 32'(bus.iss_valid), 32'd0);
    end

    // Queue fills to depth with no pops, then fetch stalls.
    for (int i = 0; i < 4; i++) serve(1, NOP);
    saw_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.ic_req_valid) saw_req = 1'b1;
      step();
    end
    chk("full no req", 32'(saw_req), 32'd0);
    chk("full head pc", bus.iss_pc, 32'h10);
    bus.iss_ready = 1'b1;
    step();
    bus.iss_ready = 1'b0;
    chk("pop no req same cycle", 32'(bus.ic_req_valid), 32'd0);
    chk("pop head pc", bus.iss_pc, 32'h14);
    step();
    chk("refill req_valid", 32'(bus.ic_req_valid), 32'd1);
    chk("refill req_pc", bus.ic_req_pc, 32'h20);

    // Flush during WAIT without response: DROP, late word discarded.
    bus.rob_flush  = 1'b1;
    bus.rob_new_pc = 32'h100;
    step();
    bus.rob_flush = 1'b0;
    chk("drop iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("drop req held", 32'(bus.ic_req_valid), 32'd1);
    chk("drop req_pc", bus.ic_req_pc, 32'h20);
    chk("drop if_pc", bus.if_pc, 32'h100);
    step();
    chk("drop still held", 32'(bus.ic_req_valid), 32'd1);
    bus.ic_resp_valid = 1'b1;
    bus.ic_resp_inst  = NOP;
    step();
    bus.ic_resp_valid = 1'b0;
    chk("drop resp req_valid", 32'(bus.ic_req_valid), 32'd0);
    chk("drop resp no push", 32'(bus.iss_valid), 32'd0);
    chk("drop resp if_pc", bus.if_pc, 32'h100);
    step();
    chk("after drop req_pc", bus.ic_req_pc, 32'h100);

    // Flush coincident with response and pop, queue holding two entries.
    serve(1, NOP);
    serve(1, NOP);
    chk("pre-flush head", bus.iss_pc, 32'h100);
    wait_req();
    chk("pre-flush req_pc", bus.ic_req_pc, 32'h108);
    bus.rob_flush     = 1'b1;
    bus.rob_new_pc    = 32'h200;
    bus.ic_resp_valid = 1'b1;
    bus.ic_resp_inst  = NOP;
    bus.iss_ready     = 1'b1;
    step();
    bus.rob_flush     = 1'b0;
    bus.ic_resp_valid = 1'b0;
    bus.iss_ready     = 1'b0;
    chk("flush iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("flush req_valid", 32'(bus.ic_req_valid), 32'd0);
    chk("flush if_pc", bus.if_pc, 32'h200);
    step();
    chk("flush next req_valid", 32'(bus.ic_req_valid), 32'd1);
    chk("flush next req_pc", bus.ic_req_pc, 32'h200);

    // rdy=0 mid-WAIT ignores a response pulse.
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.ic_resp_valid = (k == 2);
      bus.ic_resp_inst  = NOP;
      step();
    end
    bus.ic_resp_valid = 1'b0;
    rdy = 1'b1;
    chk("frozen iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("frozen req_valid", 32'(bus.ic_req_valid), 32'd1);
    chk("frozen if_pc", bus.if_pc, 32'h200);
    serve(2, NOP);
    chk("unfrozen push pc", bus.iss_pc, 32'h200);

    // Reset while in DROP.
    wait_req();
    chk("pre-rst req_pc", bus.ic_req_pc, 32'h204);
    bus.rob_flush  = 1'b1;
    bus.rob_new_pc = 32'h300;
    step();
    bus.rob_flush = 1'b0;
    chk("pre-rst drop held", 32'(bus.ic_req_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2 req_valid", 32'(bus.ic_req_valid), 32'd0);
    chk("rst2 req_pc", bus.ic_req_pc, 32'h0);
    chk("rst2 if_pc", bus.if_pc, 32'h0);
    chk("rst2 iss_valid", 32'(bus.iss_valid), 32'd0);
    serve(1, NOP);
    chk("post-rst push", 32'(bus.iss_valid), 32'd1);
    chk("post-rst push pc", bus.iss_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
